// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode, state and instruction field constants for the 8-bit CPU controller
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_WRITEBACK = 3'd3;
    localparam logic [2:0] S_HALT      = 3'd4;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS_MSB  = 8;
    localparam int RS_LSB  = 6;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Opcodes A..E are reserved; they retire like NOP but raise illegal_op.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'hA) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/alu8.sv
// rtl/alu8.sv - combinational ALU for the CPU controller (ADD/SUB/AND/OR/XOR, pass-through for LDI/MOV)
module alu8
    import cpu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res,
    output logic         carry,
    output logic         zero
);

    logic [W:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        res   = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: {carry, res} = sum;
            OP_SUB: begin
                res   = a - b;
                carry = (a < b);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_LDI, OP_MOV: res = b;
            default: res = '0;
        endcase
    end

    assign zero = (res == '0);

endmodule

// File: rtl/cpu_control_fsm.sv
// rtl/cpu_control_fsm.sv - multi-cycle fetch/decode/execute/writeback controller for the 8-bit CPU
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic [15:0]       imem_rdata,
    output logic [2:0]        rf_read_reg1,
    output logic [2:0]        rf_read_reg2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic              rf_write_enable,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              flag_zero,
    output logic              flag_carry,
    output logic              halted,
    output logic              illegal_op
);

    logic [2:0]        state;
    logic [PC_W-1:0]   pc;
    logic [15:0]       instr;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] res;

    logic [3:0]        op;
    logic [2:0]        rd;
    logic [2:0]        rs;
    logic [7:0]        imm;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   imm_pc;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic              alu_zero;

    assign op     = instr[OP_MSB:OP_LSB];
    assign rd     = instr[RD_MSB:RD_LSB];
    assign rs     = instr[RS_MSB:RS_LSB];
    assign imm    = instr[IMM_MSB:IMM_LSB];
    assign pc_inc = pc + PC_W'(1);
    assign imm_pc = PC_W'(imm);

    // LDI routes the immediate through the ALU's pass-through path so all results share one register.
    assign alu_b = (op == OP_LDI) ? DATA_W'(imm) : op_b;

    alu8 #(
        .W (DATA_W)
    ) u_alu (
        .op    (op),
        .a     (op_a),
        .b     (alu_b),
        .res   (alu_res),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            pc         <= '0;
            instr      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            res        <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ready) begin
                        instr <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    op_a  <= rf_read_data1;
                    op_b  <= rf_read_data2;
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    case (op)
                        OP_LDI, OP_MOV: begin
                            res   <= alu_res;
                            state <= S_WRITEBACK;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            res        <= alu_res;
                            flag_zero  <= alu_zero;
                            flag_carry <= alu_carry;
                            state      <= S_WRITEBACK;
                        end
                        OP_JMP: begin
                            pc    <= imm_pc;
                            state <= S_FETCH;
                        end
                        // Branch decision uses the flag left by the previous instruction.
                        OP_JZ: begin
                            pc    <= flag_zero ? imm_pc : pc_inc;
                            state <= S_FETCH;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        default: begin
                            pc    <= pc_inc;
                            state <= S_FETCH;
                        end
                    endcase
                end
                S_WRITEBACK: begin
                    pc    <= pc_inc;
                    state <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Strobes are decoded from state so the async reset clears them without waiting for a clock.
    assign imem_req        = rst_n && (state == S_FETCH);
    assign imem_addr       = pc;
    assign rf_read_reg1    = rd;
    assign rf_read_reg2    = rs;
    assign rf_write_enable = (state == S_WRITEBACK);
    assign rf_write_data   = res;
    assign illegal_op      = (state == S_EXECUTE) && is_illegal(op);

endmodule
